// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator: consumes A/B one bit pair per beat, MSB first,
// and presents a one-hot greater/less/equal result over a valid/ready handshake.
module serial_mag_comp #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_valid,
  output logic in_ready,
  input  logic a_bit,
  input  logic b_bit,
  output logic res_valid,
  input  logic res_ready,
  output logic a_g,
  output logic a_l,
  output logic a_e,
  output logic busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_p0;
  logic             dec_g_p0, dec_l_p0;
  logic             beat, res_hs, last_bit;

  // {greater, less} contribution of one bit pair; zero when the bits agree.
  function automatic logic [1:0] bit_decide(input logic a, input logic b);
    return {a & ~b, ~a & b};
  endfunction

  assign beat     = in_valid && in_ready;
  assign res_hs   = res_valid && res_ready;
  assign last_bit = (cnt_p0 == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (beat) state_d = SHIFT;
        SHIFT:   if (beat && last_bit) state_d = DONE;
        DONE:    if (res_hs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p0: bit counter and sticky decision; the first differing bit wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0   <= '0;
      dec_g_p0 <= 1'b0;
      dec_l_p0 <= 1'b0;
    end else if (clr) begin
      cnt_p0   <= '0;
      dec_g_p0 <= 1'b0;
      dec_l_p0 <= 1'b0;
    end else if (beat) begin
      if (state_q == IDLE) begin
        cnt_p0               <= CNT_W'(1);
        {dec_g_p0, dec_l_p0} <= bit_decide(a_bit, b_bit);
      end else begin
        cnt_p0 <= last_bit ? '0 : cnt_p0 + CNT_W'(1);
        if (!dec_g_p0 && !dec_l_p0)
          {dec_g_p0, dec_l_p0} <= bit_decide(a_bit, b_bit);
      end
    end
  end

  always_comb begin
    in_ready  = (state_q != DONE);
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    a_g       = res_valid && dec_g_p0;
    a_l       = res_valid && dec_l_p0;
    a_e       = res_valid && !dec_g_p0 && !dec_l_p0;
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Randomised scoreboard bench for serial_mag_comp: a driver streams words and queues the
// expected flags from integer comparison; a negedge monitor checks every presented result.
module tb_serial_mag_comp;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n, clr, in_valid, in_ready, a_bit, b_bit;
  logic res_valid, res_ready, a_g, a_l, a_e, busy;

  int checks = 0;
  int errors = 0;
  logic [2:0] sb[$];

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .a_bit(a_bit), .b_bit(b_bit),
    .res_valid(res_valid), .res_ready(res_ready),
    .a_g(a_g), .a_l(a_l), .a_e(a_e), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a > b, a < b, a == b};
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_in_ready"}, {3'b0, in_ready}, 4'h1);
    chk({nm, "_res_valid"}, {3'b0, res_valid}, 4'h0);
    chk({nm, "_flags"}, {1'b0, a_g, a_l, a_e}, 4'h0);
    chk({nm, "_busy"}, {3'b0, busy}, 4'h0);
  endtask

  // Monitor: compare every cycle a result is presented; pop on the handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got flags %b expected no result", {a_g, a_l, a_e});
      end else begin
        chk("result_flags", {1'b0, a_g, a_l, a_e}, {1'b0, sb[0]});
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  // stall: 0 none, 1 two idle cycles before every odd beat, 2 random gaps.
  // abort_at: -1 none, 0..W-1 abort at that beat, W abort while the result is pending.
  task automatic do_word(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                         input int hold, input int abort_at, input bit abort_rst);
    int ngap;
    res_ready = (hold == 0);
    for (int k = 0; k < W; k++) begin
      ngap = (stall == 1) ? ((k % 2 == 1) ? 2 : 0) : (stall == 2) ? $urandom_range(0, 2) : 0;
      repeat (ngap) begin
        in_valid = 1'b0;
        a_bit = 1'($urandom);
        b_bit = 1'($urandom);
        @(posedge clk); #1;
      end
      if (abort_at == k) begin
        if (!abort_rst) begin
          in_valid = 1'b1; a_bit = a[W-1-k]; b_bit = b[W-1-k]; clr = 1'b1;
          @(posedge clk); #1;
          clr = 1'b0; in_valid = 1'b0;
          chk_reset_outputs("after_clr");
        end else begin
          in_valid = 1'b0;
          #2 rst_n = 1'b0;
          #1 chk_reset_outputs("reset_midword");
          @(posedge clk); #2 rst_n = 1'b1;
        end
        res_ready = 1'b0;
        return;
      end
      in_valid = 1'b1; a_bit = a[W-1-k]; b_bit = b[W-1-k];
      chk("in_ready_beat", {3'b0, in_ready}, 4'h1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("latency_res_valid", {3'b0, res_valid}, 4'h1);
    sb.push_back(model(a, b));
    repeat (hold) begin
      in_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
      chk("in_ready_done", {3'b0, in_ready}, 4'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (abort_at == W) begin
      #2 rst_n = 1'b0;
      void'(sb.pop_back());
      #1 chk_reset_outputs("reset_done");
      @(posedge clk); #2 rst_n = 1'b1;
      return;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_after_hs", {3'b0, res_valid}, 4'h0);
    chk("in_ready_after_hs", {3'b0, in_ready}, 4'h1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0; res_ready = 1'b0;
    #3 chk_reset_outputs("por");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    do_word(8'hA5, 8'hA5, 0, 0, -1, 1'b0);
    do_word(8'h80, 8'h7F, 0, 0, -1, 1'b0);
    do_word(8'h3C, 8'h3D, 1, 0, -1, 1'b0);
    do_word(8'h10, 8'h01, 0, 5, -1, 1'b0);
    do_word(8'h00, 8'hFF, 0, 0, -1, 1'b0);
    do_word(8'hF0, 8'h0F, 0, 0, 4, 1'b0);
    do_word(8'h55, 8'h55, 0, 0, -1, 1'b0);
    do_word(8'hC3, 8'h12, 0, 0, 3, 1'b1);
    do_word(8'h01, 8'h02, 0, 0, -1, 1'b0);
    do_word(8'hFE, 8'hFF, 0, 2, W, 1'b1);
    do_word(8'h7F, 8'h7F, 2, 1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      do_word(ra, rb, $urandom_range(0, 2), $urandom_range(0, 3), -1, 1'b0);
    end

    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
